// File: rtl/display_arbiter_pkg.sv
// Shared types and defaults for the display arbiter.
// The arbiter shares the 8-digit 7-segment display among four requesters.
package display_arbiter_pkg;

    localparam int unsigned N_REQ        = 4;
    localparam logic [31:0] DEF_HOLD_CYC = 32'd100_000_000;
    localparam logic [31:0] DEF_IDLE_VAL = 32'h0000_0000;

    // 2'd3 is unused; the FSM treats it as a request to return to StIdle.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLock = 2'd1,
        StOpen = 2'd2
    } state_e;

endpackage

// File: rtl/display_arbiter_if.sv
// Request/data/grant bundle between the display sources and the arbiter.
// The master side is the sources; the slave side is the arbiter itself.
interface display_arbiter_if;
    import display_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [31:0]      d0;
    logic [31:0]      d1;
    logic [31:0]      d2;
    logic [31:0]      d3;
    logic [31:0]      disp_d;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       owner;
    logic             active;

    modport master (
        output req, d0, d1, d2, d3,
        input  disp_d, gnt, owner, active
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output disp_d, gnt, owner, active
    );

endinterface

// File: rtl/display_arbiter_rr_pick4.sv
// Four-way round-robin picker: first set candidate after ptr_i, wrapping to ptr_i itself.
module display_arbiter_rr_pick4 (
    input  logic [3:0] cand_i,
    input  logic [1:0] ptr_i,
    output logic       found_o,
    output logic [1:0] win_o
);

    logic [1:0] idx;

    always_comb begin
        found_o = 1'b0;
        win_o   = ptr_i;
        idx     = ptr_i;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_i + k[1:0];
            if (!found_o && cand_i[idx]) begin
                found_o = 1'b1;
                win_o   = idx;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 7-segment display with a minimum hold time before preemption.
// All outputs are registered; a new grant shows the winner's data on the same edge.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter logic [31:0] HOLD_CYC = DEF_HOLD_CYC,
    parameter logic [31:0] IDLE_VAL = DEF_IDLE_VAL
) (
    input  logic              clk,
    input  logic              rstn,
    display_arbiter_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        active_q, active_d;
    logic [31:0] data_q, data_d;

    logic [31:0] d_arr [4];
    logic [3:0]  cand;
    logic        holding;
    logic        own_req;
    logic        found;
    logic [1:0]  win;
    logic        do_grant;
    logic        go_idle;

    assign d_arr[0] = bus.d0;
    assign d_arr[1] = bus.d1;
    assign d_arr[2] = bus.d2;
    assign d_arr[3] = bus.d3;

    // The owner is masked out so one picker serves both first grant and preemption.
    assign holding = (state_q == StLock) || (state_q == StOpen);
    assign cand    = holding ? (bus.req & ~(4'b0001 << owner_q)) : bus.req;
    assign own_req = bus.req[owner_q];

    display_arbiter_rr_pick4 u_pick (
        .cand_i  (cand),
        .ptr_i   (ptr_q),
        .found_o (found),
        .win_o   (win)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        active_d = active_q;
        data_d   = d_arr[owner_q];
        do_grant = 1'b0;
        go_idle  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) do_grant = 1'b1;
                else       go_idle  = 1'b1;
            end
            StLock: begin
                if (!own_req) begin
                    if (found) do_grant = 1'b1;
                    else       go_idle  = 1'b1;
                end else if (timer_q == 32'd0) begin
                    state_d = StOpen;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            StOpen: begin
                if (!own_req) begin
                    if (found) do_grant = 1'b1;
                    else       go_idle  = 1'b1;
                end else if (found) begin
                    do_grant = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (do_grant) begin
            state_d  = StLock;
            timer_d  = HOLD_CYC - 32'd1;
            ptr_d    = win;
            owner_d  = win;
            gnt_d    = 4'b0001 << win;
            active_d = 1'b1;
            data_d   = d_arr[win];
        end else if (go_idle) begin
            state_d  = StIdle;
            timer_d  = 32'd0;
            gnt_d    = 4'b0000;
            active_d = 1'b0;
            data_d   = IDLE_VAL;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            timer_q  <= 32'd0;
            ptr_q    <= 2'd3;
            owner_q  <= 2'd0;
            gnt_q    <= 4'b0000;
            active_q <= 1'b0;
            data_q   <= IDLE_VAL;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            active_q <= active_d;
            data_q   <= data_d;
        end
    end

    assign bus.disp_d = data_q;
    assign bus.gnt    = gnt_q;
    assign bus.owner  = owner_q;
    assign bus.active = active_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed plus randomized bench for display_arbiter, checked against an ownership-level model.
module tb_display_arbiter;

    localparam logic [31:0] HOLD = 32'd4;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    display_arbiter_if bus ();

    display_arbiter #(
        .HOLD_CYC (HOLD),
        .IDLE_VAL (IDLE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Model: who owns the display, RR pointer, edges since the grant, expected display word.
    int          m_owner;
    int          m_ptr;
    int          m_age;
    logic [31:0] m_disp;
    logic [31:0] dv [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] c, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (c[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_age   = 0;
        m_disp  = IDLE;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = w;
        m_age   = 0;
        m_disp  = dv[w];
    endtask

    // One clock edge of the ownership rules: release first, preemption only after the hold.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] others;
        int         w;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
            else        m_disp = IDLE;
        end else begin
            m_age++;
            others = r & ~(4'b0001 << m_owner);
            w      = pick(others, m_ptr);
            if (!r[m_owner]) begin
                if (w >= 0) model_grant(w);
                else begin
                    m_owner = -1;
                    m_disp  = IDLE;
                end
            end else if (m_age > int'(HOLD) && w >= 0) begin
                model_grant(w);
            end else begin
                m_disp = dv[m_owner];
            end
        end
    endtask

    task automatic compare_all(input string when);
        logic [31:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        check({when, ".disp_d"}, bus.disp_d, m_disp);
        check({when, ".gnt"}, {28'd0, bus.gnt}, exp_gnt);
        check({when, ".active"}, {31'd0, bus.active}, {31'd0, m_owner >= 0});
        if (m_owner >= 0) check({when, ".owner"}, {30'd0, bus.owner}, m_owner);
    endtask

    task automatic apply(input logic [3:0] r, input string when);
        bus.req = r;
        bus.d0  = dv[0];
        bus.d1  = dv[1];
        bus.d2  = dv[2];
        bus.d3  = dv[3];
        model_edge(r);
        @(posedge clk);
        #1;
        compare_all(when);
    endtask

    initial begin
        logic [3:0] r;
        int         len;

        dv[0] = 32'h1111_1111;
        dv[1] = 32'h3333_3333;
        dv[2] = 32'h2222_2222;
        dv[3] = 32'h4444_4444;
        bus.req = 4'b0000;
        bus.d0  = dv[0];
        bus.d1  = dv[1];
        bus.d2  = dv[2];
        bus.d3  = dv[3];
        model_reset();
        #12;
        compare_all("reset");
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) apply(4'b0000, "idle");

        // Owner 0 holds for the lock period, then requester 2 preempts.
        for (int i = 0; i < 8; i++) apply(4'b0101, "pre0101");

        for (int i = 0; i < 2; i++) apply(4'b0000, "drop");

        // Requester 1 must wait out owner 0's hold.
        for (int i = 0; i < 7; i++) apply(4'b0011, "hold0011");

        // Owner 1 drops while 3 waits: direct handoff, then back to idle.
        apply(4'b1000, "handoff");
        apply(4'b0000, "release");
        apply(4'b0000, "idle2");

        // Sole owner 2 with live data.
        for (int i = 0; i < 12; i++) begin
            dv[2] = $urandom;
            apply(4'b0100, "live2");
        end
        apply(4'b0000, "drop2");

        // Asynchronous reset in the middle of a lock.
        apply(4'b0011, "lockA");
        apply(4'b0011, "lockB");
        #3;
        rstn = 1'b0;
        model_reset();
        #1;
        compare_all("asyncrst");
        #2;
        rstn = 1'b1;
        apply(4'b1111, "afterrst");
        for (int i = 0; i < 8; i++) apply(4'b1111, "all");

        // Randomized traffic: requests held for random stretches, data changing freely.
        for (int s = 0; s < 60; s++) begin
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                for (int k = 0; k < 4; k++) dv[k] = $urandom;
                if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
                apply(r, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 8-digit dynamic 7-segment display among four requesters, e.g. a register viewer, a PC monitor, a debug counter and a switch echo.
- Grants display ownership round-robin and enforces a minimum hold time, so digits do not flicker between sources.
- The registered 32-bit output drives the display block's 32-bit `d` input directly, one nibble per digit.

Parameters:
- HOLD_CYC, 32'd100_000_000: minimum ownership time in clk cycles. Legal range is 1 or more.
- IDLE_VAL, 32'h0000_0000: value shown on the display when nobody owns it.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: reset. Asynchronous, active-low.
- req, input, 4: request lines; req[i] is held high while requester i wants the display.
- d0, d1, d2, d3, input, 32 each: per-requester display data.
- disp_d, output, 32: registered data to the display.
- gnt, output, 4: one-hot grant, or all zero when the display is unowned.
- owner, output, 2: index of the current owner. Valid only while active=1.
- active, output, 1: high while some requester owns the display.

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE, disp_d=IDLE_VAL, gnt=0, owner=0, active=0.
  - timer=0, rr pointer ptr=3, so requester 0 wins the first arbitration.
- States:
  - IDLE: no owner.
  - LOCK: owner granted; hold timer running; no preemption.
  - OPEN: hold time expired; the owner can be preempted.
- Round-robin pick:
  - The candidate set is `req` with the current owner's bit masked off when preempting.
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first set bit wins.
  - On every new grant, ptr <= winner.
- All outputs are registered; they change only on the clk posedge or on reset.
  - From IDLE: req seen at edge t gives gnt, owner, active and disp_d at edge t (visible cycle t+1).
  - Latency is 1 cycle.
- IDLE:
  - If any req bit is set: pick the winner; go to LOCK; timer <= HOLD_CYC-1; disp_d <= d[winner].
  - Otherwise stay in IDLE; disp_d <= IDLE_VAL.
- LOCK:
  - Each cycle disp_d <= d[owner], so live data tracks with 1-cycle latency.
  - The timer decrements by 1 each cycle.
  - When the timer equals 0 and req[owner]=1: go to OPEN.
  - If HOLD_CYC=1, the block enters OPEN on the cycle after the grant.
  - Other requests are ignored in LOCK.
- OPEN:
  - disp_d <= d[owner]; the timer stays at 0.
  - If req[owner]=1 and another req bit is set: preempt. The RR winner among the others is granted, the block goes to LOCK, and the timer reloads.
  - If only the owner is requesting, stay in OPEN.
- Release from LOCK or OPEN (req[owner]=0 at an edge):
  - If another request is pending: grant it directly (back-to-back handoff, no IDLE cycle); go to LOCK; timer reloads.
  - Otherwise: go to IDLE; gnt=0, active=0, disp_d <= IDLE_VAL.
  - Release takes priority over timer expiry on the same edge.
- Simultaneous requests: resolved purely by RR order from ptr; there is no fixed priority beyond reset.
- Output invariants:
  - gnt is always one-hot or zero.
  - gnt[owner]=1 if and only if active=1.
  - owner holds its last value in IDLE but is don't-care there.
- Reset mid-operation: immediately returns to the reset values, regardless of state or timer.
- Timer: 32-bit down-counter. It never underflows and saturates at 0 in OPEN.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, LOCK=2'd1, OPEN=2'd2. 2'd3 is illegal and recovers to IDLE.
  - N_REQ=4.
  - Default HOLD_CYC and IDLE_VAL.
- One combinational sub-module, rr_pick4:
  - Inputs: 4-bit candidate vector, 2-bit ptr.
  - Outputs: `found` and a 2-bit winner index.
  - The same instance serves both the initial grant and preemption; the only difference is the masked candidate vector.

Test Plan (HOLD_CYC=4, IDLE_VAL=32'hFFFF_FFFF):
- Reset, then req=0 for 10 cycles -> disp_d=FFFF_FFFF, gnt=0, active=0 throughout.
- req=4'b0101 asserted at edge t, d0=1111_1111, d2=2222_2222 -> at edge t: gnt=0001, owner=0, disp_d=1111_1111. After 4 cycles the block enters OPEN; at the next edge gnt=0100, disp_d=2222_2222.
- Owner 0 holding; req=4'b0011 raised during LOCK -> gnt stays 0001 for exactly 4 cycles of LOCK, then switches to 0010. Requester 1 is never granted before the hold expires.
- Owner 1 in LOCK drops req while req[3]=1 -> next edge gnt=1000, with no IDLE cycle. Then req=0 -> next edge gnt=0, disp_d=FFFF_FFFF.
- Sole owner 2 with d2 changing every cycle -> disp_d follows d2 delayed by 1 cycle; the block remains in OPEN indefinitely with gnt=0100.
- rstn pulsed low mid-LOCK (asynchronously, between edges) -> outputs return to reset values immediately. After release with req=1111, the first grant is 0001 (ptr=3).
